nios_sys_pio_din: RTL and testbench



---
 rtl/nios_sys_pio_pkg.sv | 15 +
 rtl/nios_sys_pio_debounce.sv | 68 ++++++
 rtl/nios_sys_pio_din.sv | 113 +++++++++++
 tb/tb_nios_sys_pio_din.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_sys_pio_pkg.sv
// Shared constants for the Nios II input PIO: the register word map and the
// input synchroniser depth.
package nios_sys_pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA      = 3'd0;
    localparam logic [2:0] PIO_ADDR_MASK      = 3'd2;
    localparam logic [2:0] PIO_ADDR_CAPTURE   = 3'd3;
    localparam logic [2:0] PIO_ADDR_RISE_EN   = 3'd4;
    localparam logic [2:0] PIO_ADDR_FALL_EN   = 3'd5;
    localparam logic [2:0] PIO_ADDR_DEB_LIMIT = 3'd6;

    // Flops between the asynchronous pin and the debouncer.
    localparam int unsigned PIO_SYNC_DEPTH = 2;

endpackage

// File: rtl/nios_sys_pio_debounce.sv
// One input channel: synchroniser, debounce counter and edge detection.
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   deb_limit   cycles the synchronised input must differ before it is accepted
//   raw         asynchronous pin
//   deb         debounced level
//   rise, fall  one-cycle pulses on debounced edges
module nios_sys_pio_debounce
    import nios_sys_pio_pkg::*;
#(
    parameter int unsigned DEB_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DEB_W-1:0] deb_limit,
    input  logic             raw,
    output logic             deb,
    output logic             rise,
    output logic             fall
);

    logic [PIO_SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]          cnt_q, cnt_d;
    logic                      deb_q, deb_d;
    logic                      deb_prev_q, deb_prev_d;
    logic                      s2;
    logic                      lim_hit;

    assign s2 = sync_q[PIO_SYNC_DEPTH-1];

    // A limit of 0 or 1 accepts a change on the first differing cycle.
    assign lim_hit = (deb_limit <= DEB_W'(1)) || (cnt_q == deb_limit - DEB_W'(1));

    always_comb begin
        sync_d     = {sync_q[PIO_SYNC_DEPTH-2:0], raw};
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        if (s2 == deb_q) begin
            cnt_d = '0;
        end else if (lim_hit) begin
            deb_d = s2;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
        end
    end

    assign deb  = deb_q;
    assign rise = deb_q & ~deb_prev_q;
    assign fall = ~deb_q & deb_prev_q;

endmodule

// File: rtl/nios_sys_pio_din.sv
// Parametrised debounced input PIO, Avalon-MM slave.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata    slave write/read request
//   in_port               asynchronous raw inputs, one per channel
//   readdata              registered read data (loaded every cycle)
//   irq                   level interrupt, any unmasked captured edge
module nios_sys_pio_din
    import nios_sys_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned DEB_W       = 16,
    parameter int unsigned DEB_DEFAULT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [DEB_W-1:0] DebReset = DEB_DEFAULT[DEB_W-1:0];

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [DEB_W-1:0] deb_limit_q, deb_limit_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] deb_vec, rise_vec, fall_vec, hit, clear;
    logic             wr;
    logic             unused_wdata;

    // Upper write-data bits are dropped when WIDTH or DEB_W is below 32.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        nios_sys_pio_debounce #(
            .DEB_W (DEB_W)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .deb_limit (deb_limit_q),
            .raw       (in_port[i]),
            .deb       (deb_vec[i]),
            .rise      (rise_vec[i]),
            .fall      (fall_vec[i])
        );
    end

    assign wr    = chipselect & ~write_n;
    assign hit   = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);
    assign clear = (wr && address == PIO_ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        mask_d      = mask_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        deb_limit_d = deb_limit_q;
        // A new edge wins over a same-cycle clear so no edge is lost.
        capture_d   = hit | (capture_q & ~clear);

        if (wr) begin
            case (address)
                PIO_ADDR_MASK:      mask_d      = writedata[WIDTH-1:0];
                PIO_ADDR_RISE_EN:   rise_en_d   = writedata[WIDTH-1:0];
                PIO_ADDR_FALL_EN:   fall_en_d   = writedata[WIDTH-1:0];
                PIO_ADDR_DEB_LIMIT: deb_limit_d = writedata[DEB_W-1:0];
                default: ;
            endcase
        end

        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:      readdata_d[WIDTH-1:0] = deb_vec;
            PIO_ADDR_MASK:      readdata_d[WIDTH-1:0] = mask_q;
            PIO_ADDR_CAPTURE:   readdata_d[WIDTH-1:0] = capture_q;
            PIO_ADDR_RISE_EN:   readdata_d[WIDTH-1:0] = rise_en_q;
            PIO_ADDR_FALL_EN:   readdata_d[WIDTH-1:0] = fall_en_q;
            PIO_ADDR_DEB_LIMIT: readdata_d[DEB_W-1:0] = deb_limit_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q      <= '0;
            capture_q   <= '0;
            rise_en_q   <= '1;
            fall_en_q   <= '0;
            deb_limit_q <= DebReset;
            readdata_q  <= '0;
        end else begin
            mask_q      <= mask_d;
            capture_q   <= capture_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            deb_limit_q <= deb_limit_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(capture_q & mask_q);

endmodule

// File: tb/tb_nios_sys_pio_din.sv
// Bench for nios_sys_pio_din: directed register/timing checks on a 2-channel
// instance, then randomized traffic on a 32-channel, 4-bit-limit instance
// compared every cycle against a behavioural model.
module tb_nios_sys_pio_din;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_a;
    logic [31:0] in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nios_sys_pio_din dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_a),
        .readdata   (rd_a),
        .irq        (irq_a)
    );

    nios_sys_pio_din #(
        .WIDTH (32),
        .DEB_W (4)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_b),
        .readdata   (rd_b),
        .irq        (irq_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = rd_a;
        chipselect = 1'b0;
    endtask

    // ---------------- behavioural model of the 32-channel instance --------
    // Debounce is modelled as the length of the current run of cycles in
    // which the synchronised input disagrees with the accepted level.
    logic [31:0] m_pipe [2];   // [0] = one cycle ago, [1] = two cycles ago
    logic [31:0] m_deb, m_prev, m_mask, m_cap, m_rise, m_fall, m_rd;
    int unsigned m_lim;
    int unsigned m_run [32];

    task automatic model_reset();
        m_pipe[0] = '0;
        m_pipe[1] = '0;
        m_deb  = '0;
        m_prev = '0;
        m_mask = '0;
        m_cap  = '0;
        m_rise = '1;
        m_fall = '0;
        m_rd   = '0;
        m_lim  = 50000 % 16;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic rst, input logic cs, input logic wn,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic [31:0] inp);
        logic [31:0] rd, n_deb, hit, clr;
        int unsigned need;
        if (rst) begin
            model_reset();
        end else begin
            case (a)
                3'd0:    rd = m_deb;
                3'd2:    rd = m_mask;
                3'd3:    rd = m_cap;
                3'd4:    rd = m_rise;
                3'd5:    rd = m_fall;
                3'd6:    rd = m_lim;
                default: rd = '0;
            endcase
            need  = (m_lim == 0) ? 1 : m_lim;
            n_deb = m_deb;
            for (int i = 0; i < 32; i++) begin
                if (m_pipe[1][i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= need) begin
                        n_deb[i] = m_pipe[1][i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            hit   = (m_deb & ~m_prev & m_rise) | (~m_deb & m_prev & m_fall);
            clr   = (cs && !wn && a == 3'd3) ? wd : '0;
            m_cap = hit | (m_cap & ~clr);
            if (cs && !wn) begin
                case (a)
                    3'd2: m_mask = wd;
                    3'd4: m_rise = wd;
                    3'd5: m_fall = wd;
                    3'd6: m_lim  = wd % 16;
                    default: ;
                endcase
            end
            m_prev    = m_deb;
            m_deb     = n_deb;
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = inp;
            m_rd      = rd;
        end
    endtask

    logic [31:0] exp_rst [8];
    logic [31:0] rd;
    logic        r_rst, r_cs, r_wn;
    logic [2:0]  r_a;
    logic [31:0] r_wd, r_in;

    initial begin
        exp_rst    = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd50000, 32'd0};
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = '0;
        in_b       = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check_eq($sformatf("reset_rd%0d", a), rd, exp_rst[a]);
        end
        check_eq("reset_irq", irq_a, 0);

        // Held rising edge, limit 4: edge 0 samples the new level, capture at edge 6
        bus_write(3'd6, 32'd4);
        bus_write(3'd2, 32'd1);
        in_a[0] = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("irq_edge5", irq_a, 0);
        @(negedge clk);
        check_eq("irq_edge6", irq_a, 1);
        bus_read(3'd3, rd);
        check_eq("cap_rise", rd, 32'h1);

        // Return low (falls not enabled), clear, then a 3-cycle glitch
        in_a[0] = 1'b0;
        repeat (12) @(negedge clk);
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        check_eq("cap_w1c", rd, 32'h0);
        in_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        in_a[0] = 1'b0;
        repeat (12) @(negedge clk);
        bus_read(3'd3, rd);
        check_eq("cap_glitch", rd, 32'h0);
        check_eq("irq_glitch", irq_a, 0);

        // Falling-only on channel 1, limit 1
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'h2);
        bus_write(3'd6, 32'd1);
        in_a[1] = 1'b1;
        repeat (8) @(negedge clk);
        bus_read(3'd3, rd);
        check_eq("cap_rise_off", rd, 32'h0);
        in_a[1] = 1'b0;
        repeat (8) @(negedge clk);
        bus_read(3'd3, rd);
        check_eq("cap_fall", rd, 32'h2);
        bus_write(3'd3, 32'h2);
        in_a[1] = 1'b1;
        repeat (8) @(negedge clk);
        bus_read(3'd3, rd);
        check_eq("cap_rise_ign", rd, 32'h0);

        // Both channels captured, selective clear, irq follows MASK
        bus_write(3'd4, 32'h3);
        bus_write(3'd5, 32'h3);
        in_a = 2'b01;
        repeat (8) @(negedge clk);
        bus_read(3'd3, rd);
        check_eq("cap_both", rd, 32'h3);
        bus_read(3'd0, rd);
        check_eq("data_lvl", rd, 32'h1);
        bus_write(3'd2, 32'h1);
        check_eq("irq_m1", irq_a, 1);
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        check_eq("cap_clr0", rd, 32'h2);
        check_eq("irq_m1_clr", irq_a, 0);
        bus_write(3'd2, 32'h2);
        check_eq("irq_m2", irq_a, 1);

        // Clear of bit 0 in the very cycle its rising edge is captured
        bus_write(3'd5, 32'h0);
        in_a[0] = 1'b0;
        repeat (8) @(negedge clk);
        bus_write(3'd3, 32'h3);
        bus_read(3'd3, rd);
        check_eq("cap_pre", rd, 32'h0);
        in_a[0] = 1'b1;
        repeat (3) @(posedge clk);   // edges 0..2; capture lands on edge 3
        @(negedge clk);
        bus_write(3'd3, 32'h1);
        bus_read(3'd3, rd);
        check_eq("set_beats_clr", rd, 32'h1);

        // Randomized traffic on the 32-channel instance
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        r_in = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            // Inputs idle for a window in which DEB_LIMIT may change
            if ((cyc % 300) >= 25 && $urandom_range(0, 2) == 0)
                r_in = r_in ^ ($urandom & $urandom & $urandom);
            r_a  = 3'($urandom_range(0, 7));
            r_cs = 1'($urandom_range(0, 1));
            r_wn = ($urandom_range(0, 4) != 0);
            r_wd = $urandom;
            if (r_cs && !r_wn && r_a == 3'd6) r_a = 3'd3;
            if ((cyc % 300) == 22) begin
                r_rst = 1'b0;
                r_cs  = 1'b1;
                r_wn  = 1'b0;
                r_a   = 3'd6;
            end
            reset      = r_rst;
            address    = r_a;
            chipselect = r_cs;
            write_n    = r_wn;
            writedata  = r_wd;
            in_b       = r_in;
            @(posedge clk);
            model_step(r_rst, r_cs, r_wn, r_a, r_wd, r_in);
            @(negedge clk);
            check_eq($sformatf("rand_rd c%0d a%0d", cyc, r_a), rd_b, m_rd);
            check_eq($sformatf("rand_irq c%0d", cyc), irq_b, |(m_cap & m_mask));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
